// File: rtl/full_adder_core_pkg.sv
// rtl/full_adder_core_pkg.sv - shared constants and result type for the adder core and its consumers
package full_adder_core_pkg;

  localparam int WIDTH_MAX = 64;

  // Widest {carry, sum} result; narrower adders zero-extend into it.
  typedef struct packed {
    logic                 carry;
    logic [WIDTH_MAX-1:0] sum;
  } add_result_t;

  function automatic add_result_t make_result(input logic carry, input logic [WIDTH_MAX-1:0] sum);
    add_result_t r;
    r.carry = carry;
    r.sum   = sum;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational 1-bit full-adder cell
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder_core.sv
// rtl/full_adder_core.sv - ripple-carry adder a + b + c with optional output register
module full_adder_core
  import full_adder_core_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             ca,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    // Capture is gated by in_valid so undriven operands never reach the register.
    always_ff @(posedge clk) begin
      if (rst) begin
        s         <= '0;
        ca        <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          s  <= sum_comb;
          ca <= carry[WIDTH];
        end
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign s              = sum_comb;
    assign ca             = carry[WIDTH];
    assign out_valid      = in_valid;
  end

endmodule

// File: tb/tb_full_adder_core.sv
// tb/tb_full_adder_core.sv - self-checking bench for full_adder_core across several configurations
module tb_full_adder_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic v1 = 0, a1 = 0, b1 = 0, c1 = 0, s1, ca1, ov1;
  logic v8 = 0, c8 = 0, ca8, ov8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic v4 = 0, c4 = 0, ca4, ov4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic v16 = 0, c16 = 0, ca16, ov16;
  logic [15:0] a16 = '0, b16 = '0, s16;

  full_adder_core #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .s(s1), .ca(ca1), .out_valid(ov1));
  full_adder_core #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .s(s8), .ca(ca8), .out_valid(ov8));
  full_adder_core #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .s(s4), .ca(ca4), .out_valid(ov4));
  full_adder_core #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c(c16),
    .s(s16), .ca(ca16), .out_valid(ov16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ov1, ca1, s1} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_cycle%0d: got ov/ca/s=%b%b%b expected 000", i, ov1, ca1, s1);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({ov1, ca1, s1} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release: got ov/ca/s=%b%b%b expected 111", ov1, ca1, s1);
    end
  endtask

  task automatic test_truth_w1();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      b1 = i[0]; a1 = i[1]; c1 = i[2]; v1 = 1;
      exp = 2'(a1) + 2'(b1) + 2'(c1);
      tick();
      n_checks++;
      if ({ov1, ca1, s1} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL truth_w1 abc=%b%b%b: got ov/ca/s=%b%b%b expected 1%b", a1, b1, c1, ov1, ca1, s1, exp);
      end
    end
    v1 = 0;
  endtask

  task automatic test_w8_boundaries();
    logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'h5A};
    logic [7:0] tb [3] = '{8'h00, 8'hFF, 8'h25};
    logic       tc [3] = '{1'b1, 1'b1, 1'b0};
    logic [8:0] te [3] = '{9'h100, 9'h1FF, 9'h07F};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = tc[i]; v8 = 1;
      tick();
      n_checks++;
      if ({ov8, ca8, s8} !== {1'b1, te[i]}) begin
        n_fail++;
        $display("FAIL w8_boundary%0d: got ov=%b ca=%b s=%h expected ov=1 ca=%b s=%h", i, ov8, ca8, s8, te[i][8], te[i][7:0]);
      end
    end
    a8 = 8'h00; b8 = 8'h00; c8 = 0;
    tick();
    n_checks++;
    if ({ov8, ca8, s8} !== 10'h200) begin
      n_fail++;
      $display("FAIL w8_zero: got ov=%b ca=%b s=%h expected ov=1 ca=0 s=00", ov8, ca8, s8);
    end
  endtask

  task automatic test_w8_hold();
    a8 = 8'h5A; b8 = 8'h25; c8 = 0; v8 = 1;
    tick();
    v8 = 0; a8 = 8'h01; b8 = 8'h01; c8 = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ov8, ca8, s8} !== {2'b00, 8'h7F}) begin
        n_fail++;
        $display("FAIL w8_hold%0d: got ov=%b ca=%b s=%h expected ov=0 ca=0 s=7f", i, ov8, ca8, s8);
      end
    end
    c8 = 0;
  endtask

  task automatic test_comb_w4();
    logic [4:0] exp;
    a4 = 4'h9; b4 = 4'h8; c4 = 0; v4 = 1;
    #1;
    n_checks++;
    if ({ov4, ca4, s4} !== 6'b1_1_0001) begin
      n_fail++;
      $display("FAIL comb_w4_basic: got ov=%b ca=%b s=%h expected ov=1 ca=1 s=1", ov4, ca4, s4);
    end
    for (int i = 0; i < 20; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); v4 = 1'($urandom);
      rst = 1'($urandom);
      #2;
      exp = 5'(a4) + 5'(b4) + 5'(c4);
      n_checks++;
      if ({ov4, ca4, s4} !== {v4, exp}) begin
        n_fail++;
        $display("FAIL comb_w4_rand%0d: got ov=%b ca=%b s=%h expected ov=%b ca=%b s=%h", i, ov4, ca4, s4, v4, exp[4], exp[3:0]);
      end
    end
    rst = 0;
    tick();
  endtask

  task automatic test_midstream_reset();
    a16 = 16'h1234; b16 = 16'h1111; c16 = 0; v16 = 1;
    tick();
    rst = 1;
    a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1;
    tick();
    n_checks++;
    if ({ov16, ca16, s16} !== 18'h0) begin
      n_fail++;
      $display("FAIL midstream_reset: got ov=%b ca=%b s=%h expected all zero", ov16, ca16, s16);
    end
    rst = 0;
    tick();
    n_checks++;
    if ({ov16, ca16, s16} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL post_reset_first: got ov=%b ca=%b s=%h expected ov=1 ca=1 s=0000", ov16, ca16, s16);
    end
  endtask

  task automatic test_random_w16();
    logic [16:0] exp_sum;
    logic        exp_ov;
    rst = 1; v16 = 0;
    tick();
    rst = 0;
    exp_sum = '0;
    exp_ov  = 0;
    for (int i = 0; i < 10000; i++) begin
      v16 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if ((i % 97) == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1; end
      if (v16) exp_sum = 17'(a16) + 17'(b16) + 17'(c16);
      exp_ov = v16;
      tick();
      n_checks++;
      if ({ov16, ca16, s16} !== {exp_ov, exp_sum}) begin
        n_fail++;
        $display("FAIL random_w16 vec%0d: got ov=%b ca=%b s=%h expected ov=%b ca=%b s=%h", i, ov16, ca16, s16, exp_ov, exp_sum[16], exp_sum[15:0]);
      end
    end
    v16 = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_truth_w1();
    test_w8_boundaries();
    test_w8_hold();
    test_comb_w4();
    test_midstream_reset();
    test_random_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
